// File: rtl/seq_rshft.sv
// seq_rshft: multicycle right shifter, one bit position per clock.
// Optional build macro ARITH_SHIFT_EN adds arith_i (sign-fill shifts).
module seq_rshft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [AMT_W-1:0] amt_i,
`ifdef ARITH_SHIFT_EN
    input  logic             arith_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] work_q;
    logic [AMT_W-1:0] cnt_q;
    logic [WIDTH-1:0] res_q;
    logic             fill;
    logic [WIDTH-1:0] shift_d;
    logic             last_step;

`ifdef ARITH_SHIFT_EN
    // Fill bit is fixed at load: sign of the operand, only for arithmetic requests.
    logic sign_q;

    // Capture the fill bit together with the operand on an accepted start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sign_q <= 1'b0;
        end else if (state_q == IDLE && start_i) begin
            sign_q <= arith_i & data_i[WIDTH-1];
        end
    end

    assign fill = sign_q;
`else
    assign fill = 1'b0;
`endif

    // One-position right shift of the work register with the selected fill.
    assign shift_d   = {fill, work_q[WIDTH-1:1]};
    assign last_step = (cnt_q == AMT_W'(1));

    // Sequencer: load on start, shift cnt times, then one DONE cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        work_q <= data_i;
                        cnt_q  <= amt_i;
                        if (amt_i == '0) begin
                            res_q   <= data_i;
                            state_q <= DONE;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= shift_d;
                    cnt_q  <= cnt_q - AMT_W'(1);
                    if (last_step) begin
                        res_q   <= shift_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign data_o = res_q;

endmodule

// File: tb/tb_seq_rshft.sv
// tb_seq_rshft: randomized and directed checks of seq_rshft
// against an arithmetic reference model.
module tb_seq_rshft;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] din;
    logic [3:0] amt;
    logic       arith;
    logic       busy;
    logic       done;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

    seq_rshft #(.WIDTH(8), .AMT_W(4)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .data_i  (din),
        .amt_i   (amt),
`ifdef ARITH_SHIFT_EN
        .arith_i (arith),
`endif
        .busy_o  (busy),
        .done_o  (done),
        .data_o  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value interpreted as signed (arith) or unsigned, floor-divided by 2^a.
    function automatic logic [7:0] ref_shift(input logic [7:0] d,
                                             input int a,
                                             input bit ar);
        int v;
        v = int'(d);
        if (ar && d[7]) v = v - 256;
        v = v >>> a;
        return v[7:0];
    endfunction

    // Start one operation and follow it until busy falls.
    task automatic do_op(input logic [7:0] d, input logic [3:0] a,
                         input bit ar, output logic [7:0] res,
                         output int lat, output int bcyc,
                         output int dones, output bit tmo);
        res = 8'hxx; lat = -1; bcyc = 0; dones = 0; tmo = 1'b1;
        @(negedge clk);
        start = 1'b1; din = d; amt = a; arith = ar;
        @(posedge clk); #1;
        start = 1'b0; din = $urandom; amt = $urandom; arith = $urandom;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (busy) bcyc++;
            if (done) begin
                dones++; lat = k; res = dout;
            end
            if (!busy) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; din = '0; amt = '0; arith = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dout !== 8'h00) begin
            errors++;
            $display("FAIL reset busy=%b done=%b data=%h want 0 0 00",
                     busy, done, dout);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b want 0", busy);
        end
    endtask

    task automatic check_op(input string nm, input logic [7:0] d,
                            input logic [3:0] a, input bit ar);
        logic [7:0] r; int lat, bc, dn; bit tmo;
        logic [7:0] exp;
        exp = ref_shift(d, int'(a), ar);
        do_op(d, a, ar, r, lat, bc, dn, tmo);
        checks++;
        if (tmo || r !== exp || lat != int'(a) || bc != int'(a) + 1 || dn != 1) begin
            errors++;
            $display("FAIL %s d=%h a=%0d ar=%0b got res=%h lat=%0d busy=%0d dones=%0d tmo=%0b want res=%h lat=%0d busy=%0d dones=1",
                     nm, d, a, ar, r, lat, bc, dn, tmo, exp, a, a + 1);
        end
    endtask

    task automatic test_logical();
        check_op("logical_b4_3", 8'hB4, 4'd3, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (dout !== 8'h16 || done !== 1'b0) begin
                errors++;
                $display("FAIL hold_16 data=%h done=%b want 16 0", dout, done);
            end
        end
    endtask

    task automatic test_zero();
        check_op("zero_amt", 8'h5A, 4'd0, 1'b0);
    endtask

    task automatic test_overrange();
        check_op("over_ff_15", 8'hFF, 4'd15, 1'b0);
        check_op("over_a5_8", 8'hA5, 4'd8, 1'b0);
    endtask

    task automatic test_collision();
        int dn = 0;
        @(negedge clk);
        start = 1'b1; din = 8'h80; amt = 4'd2; arith = 1'b0;
        @(posedge clk); #1;
        if (done) dn++;
        din = 8'h01; amt = 4'd1;
        @(posedge clk); #1;
        if (done) dn++;
        start = 1'b0;
        @(posedge clk); #1;
        if (done) dn++;
        checks++;
        if (done !== 1'b1 || dout !== 8'h20) begin
            errors++;
            $display("FAIL coll_done done=%b data=%h want 1 20", done, dout);
        end
        start = 1'b1; din = 8'h01; amt = 4'd1;
        @(posedge clk); #1;
        if (done) dn++;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL coll_done_start busy=%b want 0", busy);
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        checks++;
        if (dn != 1 || dout !== 8'h20 || busy !== 1'b0) begin
            errors++;
            $display("FAIL coll_final dones=%0d data=%h busy=%b want 1 20 0",
                     dn, dout, busy);
        end
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        @(negedge clk);
        start = 1'b1; din = 8'hF0; amt = 4'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dout !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid busy=%b done=%b data=%h want 0 0 00",
                     busy, done, dout);
        end
        repeat (8) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL rst_mid_done dones=%0d want 0", dn);
        end
        rst_n = 1'b1;
        check_op("after_rst_0f_1", 8'h0F, 4'd1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d; logic [3:0] a; bit ar;
            d = $urandom; a = $urandom;
`ifdef ARITH_SHIFT_EN
            ar = $urandom;
`else
            ar = 1'b0;
`endif
            check_op("random", d, a, ar);
        end
    endtask

    task automatic test_back_to_back();
        check_op("b2b_0", 8'hC3, 4'd1, 1'b0);
        check_op("b2b_1", 8'h3C, 4'd0, 1'b0);
        check_op("b2b_2", 8'hE7, 4'd4, 1'b0);
    endtask

`ifdef ARITH_SHIFT_EN
    task automatic test_arith();
        check_op("arith_90_2", 8'h90, 4'd2, 1'b1);
        check_op("logic_90_2", 8'h90, 4'd2, 1'b0);
        check_op("arith_90_12", 8'h90, 4'd12, 1'b1);
        check_op("arith_70_12", 8'h70, 4'd12, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_logical();
        test_zero();
        test_overrange();
        test_collision();
        test_reset_mid();
        test_back_to_back();
`ifdef ARITH_SHIFT_EN
        test_arith();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
